// File: rtl/ar_srl_fifo_lvl.sv
// SRL shift-register FIFO with registered output stage, occupancy count,
// runtime almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module ar_srl_fifo_lvl #(
    parameter int unsigned width   = 128,
    parameter int unsigned l2depth = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CLR,
    input  logic               ENQ,
    input  logic [width-1:0]   D_IN,
    output logic               FULL_N,
    input  logic               DEQ,
    output logic [width-1:0]   D_OUT,
    output logic               EMPTY_N,
    input  logic [l2depth:0]   AF_LEVEL,
    input  logic [l2depth:0]   AE_LEVEL,
    output logic [l2depth:0]   COUNT,
    output logic               ALMOST_FULL,
    output logic               ALMOST_EMPTY,
    output logic               OVF,
    output logic               UNF
);

    localparam int unsigned depth = 1 << l2depth;
    localparam int unsigned cw    = l2depth + 1;

    logic [width-1:0]   srl [depth];
    logic [cw-1:0]      pos;

    logic               acc_enq_c;
    logic               acc_deq_c;
    logic               sdx_c;
    logic [l2depth-1:0] rd_idx_c;
    logic [cw-1:0]      pos_nx_c;
    logic [cw-1:0]      count_nx_c;
    logic               clr_c;

    // Accept/transfer decisions and next occupancy
    always_comb begin
        clr_c      = !RST_N || CLR;
        acc_enq_c  = ENQ && FULL_N;
        acc_deq_c  = DEQ && EMPTY_N;
        sdx_c      = (pos != '0) && (!EMPTY_N || acc_deq_c);
        rd_idx_c   = l2depth'(pos - cw'(1));
        pos_nx_c   = pos;
        if (acc_enq_c && !sdx_c) begin
            pos_nx_c = pos + cw'(1);
        end else if (!acc_enq_c && sdx_c) begin
            pos_nx_c = pos - cw'(1);
        end
        count_nx_c = COUNT + cw'(acc_enq_c) - cw'(acc_deq_c);
    end

    // SRL storage is never cleared; only pos tracks validity
    always_ff @(posedge CLK) begin
        if (!clr_c && acc_enq_c) begin
            srl[0] <= D_IN;
            for (int i = 1; i < int'(depth); i++) begin
                srl[i] <= srl[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_c) begin
            pos          <= '0;
            FULL_N       <= 1'b1;
            EMPTY_N      <= 1'b0;
            D_OUT        <= '0;
            COUNT        <= '0;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            OVF          <= 1'b0;
            UNF          <= 1'b0;
        end else begin
            pos          <= pos_nx_c;
            FULL_N       <= (pos_nx_c != cw'(depth));
            if (sdx_c) begin
                D_OUT   <= srl[rd_idx_c];
                EMPTY_N <= 1'b1;
            end else if (acc_deq_c) begin
                EMPTY_N <= 1'b0;
            end
            COUNT        <= count_nx_c;
            ALMOST_FULL  <= (count_nx_c >= AF_LEVEL);
            ALMOST_EMPTY <= (count_nx_c <= AE_LEVEL);
            OVF          <= OVF || (ENQ && !FULL_N);
            UNF          <= UNF || (DEQ && !EMPTY_N);
        end
    end

endmodule

// File: tb/tb_ar_srl_fifo_lvl.sv
// Directed, table-driven bench for ar_srl_fifo_lvl with l2depth=2 (CAP=5).
module tb_ar_srl_fifo_lvl;

    localparam int unsigned W  = 8;
    localparam int unsigned L2 = 2;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          CLR;
    logic          ENQ;
    logic [W-1:0]  D_IN;
    logic          FULL_N;
    logic          DEQ;
    logic [W-1:0]  D_OUT;
    logic          EMPTY_N;
    logic [L2:0]   AF_LEVEL;
    logic [L2:0]   AE_LEVEL;
    logic [L2:0]   COUNT;
    logic          ALMOST_FULL;
    logic          ALMOST_EMPTY;
    logic          OVF;
    logic          UNF;

    int checks = 0;
    int errors = 0;

    ar_srl_fifo_lvl #(.width(W), .l2depth(L2)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .ENQ(ENQ), .D_IN(D_IN), .FULL_N(FULL_N),
        .DEQ(DEQ), .D_OUT(D_OUT), .EMPTY_N(EMPTY_N),
        .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .COUNT(COUNT),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         enq;
        logic [W-1:0] din;
        logic         deq;
        logic         clr;
        logic [L2:0]  af;
        logic [L2:0]  ae;
        logic         full_n;
        logic         empty_n;
        logic         chk_dout;
        logic [W-1:0] dout;
        logic [L2:0]  count;
        logic         alf;
        logic         ale;
        logic         ovf;
        logic         unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int enq, input int din, input int deq, input int clr,
                       input int af, input int ae, input int full_n, input int empty_n,
                       input int chk_dout, input int dout, input int count,
                       input int alf, input int ale, input int ovf, input int unf);
        vec_t v;
        v.enq = 1'(enq);       v.din = W'(din);      v.deq = 1'(deq);
        v.clr = 1'(clr);       v.af = (L2+1)'(af);   v.ae = (L2+1)'(ae);
        v.full_n = 1'(full_n); v.empty_n = 1'(empty_n);
        v.chk_dout = 1'(chk_dout); v.dout = W'(dout);
        v.count = (L2+1)'(count);
        v.alf = 1'(alf); v.ale = 1'(ale); v.ovf = 1'(ovf); v.unf = 1'(unf);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " FULL_N"},       int'(FULL_N),       int'(v.full_n));
        chk({tag, " EMPTY_N"},      int'(EMPTY_N),      int'(v.empty_n));
        if (v.chk_dout) chk({tag, " D_OUT"}, int'(D_OUT), int'(v.dout));
        chk({tag, " COUNT"},        int'(COUNT),        int'(v.count));
        chk({tag, " ALMOST_FULL"},  int'(ALMOST_FULL),  int'(v.alf));
        chk({tag, " ALMOST_EMPTY"}, int'(ALMOST_EMPTY), int'(v.ale));
        chk({tag, " OVF"},          int'(OVF),          int'(v.ovf));
        chk({tag, " UNF"},          int'(UNF),          int'(v.unf));
    endtask

    task automatic step(input logic enq, input logic [W-1:0] din, input logic deq, input logic clr);
        @(negedge CLK);
        ENQ = enq; D_IN = din; DEQ = deq; CLR = clr;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t rv;
        RST_N = 1'b0; CLR = 1'b0; ENQ = 1'b0; DEQ = 1'b0; D_IN = '0;
        AF_LEVEL = 3'd3; AE_LEVEL = 3'd1;

        //  enq din  deq clr af ae | full emp chkd dout cnt alf ale ovf unf
        add(1, 'hA1, 0, 0, 3, 1,   1, 0, 0, 'h00, 1, 0, 1, 0, 0);
        add(0, 'h00, 0, 0, 3, 1,   1, 1, 1, 'hA1, 1, 0, 1, 0, 0);
        add(0, 'h00, 1, 0, 3, 1,   1, 0, 0, 'h00, 0, 0, 1, 0, 0);
        add(1, 'h01, 0, 0, 3, 1,   1, 0, 0, 'h00, 1, 0, 1, 0, 0);
        add(1, 'h02, 0, 0, 3, 1,   1, 1, 1, 'h01, 2, 0, 0, 0, 0);
        add(1, 'h03, 0, 0, 3, 1,   1, 1, 1, 'h01, 3, 1, 0, 0, 0);
        add(1, 'h04, 0, 0, 3, 1,   1, 1, 1, 'h01, 4, 1, 0, 0, 0);
        add(1, 'h05, 0, 0, 3, 1,   0, 1, 1, 'h01, 5, 1, 0, 0, 0);
        add(1, 'h06, 0, 0, 3, 1,   0, 1, 1, 'h01, 5, 1, 0, 1, 0);
        add(0, 'h00, 1, 0, 3, 1,   1, 1, 1, 'h02, 4, 1, 0, 1, 0);
        add(0, 'h00, 1, 0, 3, 1,   1, 1, 1, 'h03, 3, 1, 0, 1, 0);
        add(0, 'h00, 1, 0, 3, 1,   1, 1, 1, 'h04, 2, 0, 0, 1, 0);
        add(0, 'h00, 1, 0, 3, 1,   1, 1, 1, 'h05, 1, 0, 1, 1, 0);
        add(0, 'h00, 1, 0, 3, 1,   1, 0, 0, 'h00, 0, 0, 1, 1, 0);
        add(0, 'h00, 1, 0, 3, 1,   1, 0, 0, 'h00, 0, 0, 1, 1, 1);
        add(1, 'h77, 0, 1, 3, 1,   1, 0, 1, 'h00, 0, 0, 1, 0, 0);
        add(1, 'h11, 0, 0, 3, 1,   1, 0, 0, 'h00, 1, 0, 1, 0, 0);
        add(1, 'h12, 0, 0, 3, 1,   1, 1, 1, 'h11, 2, 0, 0, 0, 0);
        add(1, 'h13, 0, 0, 3, 1,   1, 1, 1, 'h11, 3, 1, 0, 0, 0);
        add(1, 'h14, 0, 0, 3, 1,   1, 1, 1, 'h11, 4, 1, 0, 0, 0);
        add(1, 'h15, 1, 1, 3, 1,   1, 0, 1, 'h00, 0, 0, 1, 0, 0);
        add(0, 'h00, 1, 0, 3, 1,   1, 0, 0, 'h00, 0, 0, 1, 0, 1);
        add(0, 'h00, 0, 0, 3, 1,   1, 0, 0, 'h00, 0, 0, 1, 0, 1);
        add(0, 'h00, 0, 0, 0, 5,   1, 0, 0, 'h00, 0, 1, 1, 0, 1);
        add(0, 'h00, 0, 0, 3, 1,   1, 0, 0, 'h00, 0, 0, 1, 0, 1);

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        rv = '{enq: 1'b0, din: '0, deq: 1'b0, clr: 1'b0, af: 3'd3, ae: 3'd1,
               full_n: 1'b1, empty_n: 1'b0, chk_dout: 1'b1, dout: '0, count: '0,
               alf: 1'b0, ale: 1'b1, ovf: 1'b0, unf: 1'b0};
        chk_all("reset", rv);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            @(negedge CLK);
            AF_LEVEL = vecs[i].af;
            AE_LEVEL = vecs[i].ae;
            ENQ = vecs[i].enq; D_IN = vecs[i].din; DEQ = vecs[i].deq; CLR = vecs[i].clr;
            @(posedge CLK);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Sustained ENQ+DEQ: after a 2-cycle fill, one word out per cycle
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, W'(i + 1), (i >= 2), 1'b0);
            if (i >= 1) begin
                chk($sformatf("stream%0d EMPTY_N", i), int'(EMPTY_N), 1);
                chk($sformatf("stream%0d D_OUT", i), int'(D_OUT), i);
                chk($sformatf("stream%0d COUNT", i), int'(COUNT), 2);
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("drain1 D_OUT", int'(D_OUT), 100);
        chk("drain1 COUNT", int'(COUNT), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("drain2 EMPTY_N", int'(EMPTY_N), 0);
        chk("drain2 COUNT", int'(COUNT), 0);
        chk("drain2 UNF", int'(UNF), 0);

        // Reset wins over ENQ in the same cycle
        @(negedge CLK);
        RST_N = 1'b0; ENQ = 1'b1; D_IN = 8'h5A; DEQ = 1'b0; CLR = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_enq COUNT", int'(COUNT), 0);
        @(negedge CLK);
        RST_N = 1'b1; ENQ = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_enq EMPTY_N", int'(EMPTY_N), 0);
        chk("rst_enq OVF", int'(OVF), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
